// File: rtl/mem_result_checker.sv
// In-order memory-transaction checker: queues reference-model expectations and
// compares each against the next observed DUT memory transaction.
package mem_result_checker_pkg;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        write;   // 1 = WRITE, 0 = READ
  } data_item_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } instr_item_t;

  // Distinguishable "no instruction" marker (all-ones encoding is not a valid RV instruction).
  localparam instr_item_t NO_INST = '{pc: 32'h0, insn: 32'hFFFF_FFFF};

  typedef struct packed {
    instr_item_t input_instruction;
    data_item_t  model_result;
    data_item_t  dut_result;
    logic [2:0]  error_champ;   // [0] data, [1] addr, [2] direction mismatch
  } error_data_item_t;

  localparam error_data_item_t REC_RST = '{
    input_instruction: NO_INST,
    model_result:      '0,
    dut_result:        '0,
    error_champ:       '0
  };

endpackage

module mem_result_checker
  import mem_result_checker_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mdl_valid,
  output logic             mdl_ready,
  input  data_item_t       mdl_item,
  input  instr_item_t      mdl_instr,
  input  logic             dut_valid,
  input  data_item_t       dut_item,
  output logic             cmp_valid,
  output error_data_item_t cmp_rec,
  output logic             cmp_error,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] error_cnt,
  output logic             orphan_flag,
  output logic             ovf_flag,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    instr_item_t instr;
    data_item_t  item;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             full, is_empty, push, pop, bypass, fire;
  logic             orphan_hit, ovf_hit;
  entry_t           ref_e;
  logic [2:0]       champ;
  error_data_item_t rec_d;
  logic             cmp_valid_q, cmp_error_q, orphan_q, ovf_q;
  error_data_item_t cmp_rec_q;
  logic [CNT_W-1:0] match_q, error_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Queue status, accept/compare decisions and the comparison record.
  always_comb begin
    full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    is_empty   = (wr_q == rd_q);
    pop        = dut_valid && !is_empty;
    bypass     = dut_valid && is_empty && mdl_valid;
    push       = mdl_valid && !full && !bypass;
    fire       = pop || bypass;
    orphan_hit = dut_valid && is_empty && !mdl_valid;
    ovf_hit    = mdl_valid && full && !dut_valid;
    ref_e      = is_empty ? '{instr: mdl_instr, item: mdl_item} : mem_q[rd_q[AW-1:0]];
    champ[0]   = (ref_e.item.data  != dut_item.data);
    champ[1]   = (ref_e.item.addr  != dut_item.addr);
    champ[2]   = (ref_e.item.write != dut_item.write);
    rec_d      = '{input_instruction: ref_e.instr, model_result: ref_e.item,
                   dut_result: dut_item, error_champ: champ};
    wr_d       = push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d       = pop  ? rd_q + (AW+1)'(1) : rd_q;
  end

  // Queue storage holds data only; pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= '{instr: mdl_instr, item: mdl_item};
  end

  // Pointers, registered comparison result, saturating counters and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cmp_valid_q <= 1'b0;
      cmp_error_q <= 1'b0;
      cmp_rec_q   <= REC_RST;
      match_q     <= '0;
      error_q     <= '0;
      orphan_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cmp_valid_q <= fire;
      cmp_error_q <= fire && (|champ);
      if (fire) begin
        cmp_rec_q <= rec_d;
        if (|champ) error_q <= sat_inc(error_q);
        else        match_q <= sat_inc(match_q);
      end
      if (orphan_hit) orphan_q <= 1'b1;
      if (ovf_hit)    ovf_q    <= 1'b1;
    end
  end

  assign mdl_ready   = !full;
  assign empty       = is_empty;
  assign cmp_valid   = cmp_valid_q;
  assign cmp_rec     = cmp_rec_q;
  assign cmp_error   = cmp_error_q;
  assign match_cnt   = match_q;
  assign error_cnt   = error_q;
  assign orphan_flag = orphan_q;
  assign ovf_flag    = ovf_q;

endmodule

// File: tb/tb_mem_result_checker.sv
// Bench for mem_result_checker: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_mem_result_checker;
  import mem_result_checker_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             mdl_valid, mdl_ready, dut_valid;
  data_item_t       mdl_item, dut_item;
  instr_item_t      mdl_instr;
  logic             cmp_valid, cmp_error, orphan_flag, ovf_flag, empty;
  error_data_item_t cmp_rec;
  logic [CNT_W-1:0] match_cnt, error_cnt;

  always #5 clk = ~clk;

  mem_result_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .mdl_valid(mdl_valid), .mdl_ready(mdl_ready), .mdl_item(mdl_item), .mdl_instr(mdl_instr),
    .dut_valid(dut_valid), .dut_item(dut_item),
    .cmp_valid(cmp_valid), .cmp_rec(cmp_rec), .cmp_error(cmp_error),
    .match_cnt(match_cnt), .error_cnt(error_cnt),
    .orphan_flag(orphan_flag), .ovf_flag(ovf_flag), .empty(empty)
  );

  // Reference model state
  typedef struct { instr_item_t instr; data_item_t item; } ent_t;
  ent_t             q[$];
  logic             m_cv, m_ce, m_orph, m_ovf;
  error_data_item_t m_rec;
  int               m_match, m_err;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic data_item_t rand_item();
    data_item_t d;
    d.data  = $urandom;
    d.addr  = $urandom & 32'hFFFF_FFFC;
    d.write = 1'($urandom_range(0, 1));
    return d;
  endfunction

  function automatic instr_item_t rand_instr();
    instr_item_t i;
    i.pc   = $urandom & 32'hFFFF_FFFC;
    i.insn = $urandom & 32'h7FFF_FFFF;
    return i;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cv = 1'b0; m_ce = 1'b0; m_orph = 1'b0; m_ovf = 1'b0;
    m_rec = '0;
    m_rec.input_instruction = NO_INST;
    m_match = 0; m_err = 0;
  endtask

  task automatic model_compare(input ent_t e, input data_item_t di);
    logic [2:0] ch;
    ch[0] = (e.item.data  != di.data);
    ch[1] = (e.item.addr  != di.addr);
    ch[2] = (e.item.write != di.write);
    m_rec.input_instruction = e.instr;
    m_rec.model_result      = e.item;
    m_rec.dut_result        = di;
    m_rec.error_champ       = ch;
    m_cv = 1'b1;
    m_ce = (ch != 3'b000);
    if (ch == 3'b000) m_match = (m_match < CMAX) ? m_match + 1 : CMAX;
    else              m_err   = (m_err   < CMAX) ? m_err   + 1 : CMAX;
  endtask

  // Drive one clock cycle of inputs, advance the model, return #1 after the edge.
  task automatic cycle(input logic mv, input data_item_t mi, input instr_item_t ins,
                       input logic dv, input data_item_t di);
    bit   was_full;
    bit   bypassed;
    ent_t e;
    @(negedge clk);
    mdl_valid = mv; mdl_item = mi; mdl_instr = ins;
    dut_valid = dv; dut_item = di;
    was_full = (q.size() == DEPTH);
    bypassed = 1'b0;
    m_cv = 1'b0; m_ce = 1'b0;
    if (dv) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        model_compare(e, di);
      end else if (mv) begin
        e = '{ins, mi};
        model_compare(e, di);
        bypassed = 1'b1;
      end else begin
        m_orph = 1'b1;
      end
    end
    if (mv && !bypassed) begin
      if (!was_full) q.push_back('{ins, mi});
      else if (!dv)  m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    mdl_valid = 1'b0; dut_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (cmp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_valid got=%b exp=0", cmp_valid); end
    n_checks++; if (cmp_error !== 1'b0) begin n_fail++; $display("FAIL reset_cmp_error got=%b exp=0", cmp_error); end
    n_checks++; if (cmp_rec !== REC_RST) begin n_fail++; $display("FAIL reset_cmp_rec got=%h exp=%h", cmp_rec, REC_RST); end
    n_checks++; if (match_cnt !== '0 || error_cnt !== '0) begin n_fail++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", match_cnt, error_cnt); end
    n_checks++; if (orphan_flag !== 1'b0 || ovf_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", orphan_flag, ovf_flag); end
    n_checks++; if (empty !== 1'b1 || mdl_ready !== 1'b1) begin n_fail++; $display("FAIL reset_queue got empty=%b ready=%b exp=1/1", empty, mdl_ready); end
  endtask

  task automatic test_match();
    data_item_t  a;
    instr_item_t ia;
    apply_reset();
    a = '{data: 32'h1234_5678, addr: 32'h100, write: 1'b1};
    ia = rand_instr();
    cycle(1'b1, a, ia, 1'b0, '0);
    n_checks++; if (empty !== 1'b0 || cmp_valid !== 1'b0) begin n_fail++; $display("FAIL match_push got empty=%b cv=%b exp=0/0", empty, cmp_valid); end
    cycle(1'b0, '0, '0, 1'b1, a);
    n_checks++; if (cmp_valid !== 1'b1) begin n_fail++; $display("FAIL match_cmp_valid got=%b exp=1", cmp_valid); end
    n_checks++; if (cmp_rec.error_champ !== 3'b000 || cmp_error !== 1'b0) begin n_fail++; $display("FAIL match_champ got=%b err=%b exp=000/0", cmp_rec.error_champ, cmp_error); end
    n_checks++; if (match_cnt !== 4'd1 || empty !== 1'b1) begin n_fail++; $display("FAIL match_cnt_empty got=%0d/%b exp=1/1", match_cnt, empty); end
    n_checks++; if (cmp_rec !== m_rec) begin n_fail++; $display("FAIL match_rec got=%h exp=%h", cmp_rec, m_rec); end
    idle();
    n_checks++; if (cmp_valid !== 1'b0 || cmp_rec !== m_rec) begin n_fail++; $display("FAIL match_pulse_hold got cv=%b rec=%h exp 0/%h", cmp_valid, cmp_rec, m_rec); end
  endtask

  task automatic test_mismatch();
    data_item_t  a, b;
    instr_item_t ia;
    apply_reset();
    a = '{data: 32'hA, addr: 32'h100, write: 1'b1};
    b = '{data: 32'hB, addr: 32'h104, write: 1'b0};
    ia = '{pc: 32'h8000_0040, insn: 32'h0051_2023};
    cycle(1'b1, a, ia, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, b);
    n_checks++; if (cmp_rec.error_champ !== 3'b111 || cmp_error !== 1'b1) begin n_fail++; $display("FAIL mism_champ got=%b err=%b exp=111/1", cmp_rec.error_champ, cmp_error); end
    n_checks++; if (error_cnt !== 4'd1 || match_cnt !== 4'd0) begin n_fail++; $display("FAIL mism_cnt got=%0d/%0d exp=1/0", error_cnt, match_cnt); end
    n_checks++; if (cmp_rec.input_instruction !== ia) begin n_fail++; $display("FAIL mism_instr got=%h exp=%h", cmp_rec.input_instruction, ia); end
  endtask

  task automatic test_full_wrap();
    data_item_t  items [DEPTH];
    instr_item_t ins;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      items[i] = '{data: 32'(i), addr: 32'h200 + 32'(4 * i), write: 1'(i & 1)};
      cycle(1'b1, items[i], rand_instr(), 1'b0, '0);
    end
    n_checks++; if (mdl_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", mdl_ready); end
    ins = rand_instr();
    cycle(1'b1, rand_item(), ins, 1'b0, '0);
    n_checks++; if (ovf_flag !== 1'b1 || mdl_ready !== 1'b0) begin n_fail++; $display("FAIL full_ovf got ovf=%b ready=%b exp=1/0", ovf_flag, mdl_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, '0, 1'b1, items[i]);
      n_checks++;
      if (cmp_valid !== 1'b1 || cmp_rec.error_champ !== 3'b000 || cmp_rec.model_result.data !== 32'(i))
        begin n_fail++; $display("FAIL full_drain_%0d got cv=%b ch=%b data=%h exp 1/000/%h", i, cmp_valid, cmp_rec.error_champ, cmp_rec.model_result.data, i); end
    end
    n_checks++; if (empty !== 1'b1 || match_cnt !== 4'(m_match)) begin n_fail++; $display("FAIL full_end got empty=%b match=%0d exp 1/%0d", empty, match_cnt, m_match); end
    // Pointers now sit past the wrap point; a fresh push/compare must still work.
    items[0] = rand_item();
    cycle(1'b1, items[0], rand_instr(), 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, items[0]);
    n_checks++; if (cmp_valid !== 1'b1 || cmp_rec !== m_rec || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_cmp got cv=%b rec=%h exp 1/%h", cmp_valid, cmp_rec, m_rec); end
  endtask

  task automatic test_orphan_bypass();
    data_item_t  a;
    instr_item_t ia;
    apply_reset();
    cycle(1'b0, '0, '0, 1'b1, rand_item());
    n_checks++; if (orphan_flag !== 1'b1 || cmp_valid !== 1'b0) begin n_fail++; $display("FAIL orphan got flag=%b cv=%b exp 1/0", orphan_flag, cmp_valid); end
    n_checks++; if (match_cnt !== '0 || error_cnt !== '0) begin n_fail++; $display("FAIL orphan_cnt got=%0d/%0d exp=0/0", match_cnt, error_cnt); end
    a = rand_item(); ia = rand_instr();
    cycle(1'b1, a, ia, 1'b1, a);
    n_checks++; if (cmp_valid !== 1'b1 || cmp_rec.error_champ !== 3'b000 || empty !== 1'b1) begin n_fail++; $display("FAIL bypass got cv=%b ch=%b empty=%b exp 1/000/1", cmp_valid, cmp_rec.error_champ, empty); end
    n_checks++; if (cmp_rec.input_instruction !== ia || match_cnt !== 4'd1) begin n_fail++; $display("FAIL bypass_rec got instr=%h match=%0d exp %h/1", cmp_rec.input_instruction, match_cnt, ia); end
    idle();
    n_checks++; if (orphan_flag !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky got=%b empty=%b exp 1/1", orphan_flag, empty); end
  endtask

  task automatic test_reset_mid();
    data_item_t a [3];
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      a[i] = rand_item();
      cycle(1'b1, a[i], rand_instr(), 1'b0, '0);
    end
    @(negedge clk);
    dut_valid = 1'b1; dut_item = a[0]; mdl_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (cmp_valid !== 1'b0 || cmp_rec !== REC_RST) begin n_fail++; $display("FAIL midrst_cmp got cv=%b rec=%h exp 0/%h", cmp_valid, cmp_rec, REC_RST); end
    n_checks++; if (empty !== 1'b1 || mdl_ready !== 1'b1 || match_cnt !== '0) begin n_fail++; $display("FAIL midrst_state got empty=%b ready=%b match=%0d exp 1/1/0", empty, mdl_ready, match_cnt); end
    @(negedge clk);
    rst = 1'b0; dut_valid = 1'b0;
    model_reset();
    a[0] = rand_item();
    cycle(1'b1, a[0], rand_instr(), 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b1, a[0]);
    n_checks++; if (cmp_valid !== 1'b1 || cmp_rec !== m_rec || match_cnt !== 4'd1) begin n_fail++; $display("FAIL midrst_after got cv=%b match=%0d exp 1/1", cmp_valid, match_cnt); end
  endtask

  task automatic test_saturate();
    data_item_t a;
    apply_reset();
    for (int i = 0; i < CMAX + 3; i++) begin
      a = rand_item();
      cycle(1'b1, a, rand_instr(), 1'b1, a);
    end
    n_checks++; if (match_cnt !== 4'd15) begin n_fail++; $display("FAIL saturate got=%0d exp=15", match_cnt); end
  endtask

  task automatic test_back_to_back();
    data_item_t a [DEPTH];
    data_item_t x;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      a[i] = rand_item();
      cycle(1'b1, a[i], rand_instr(), 1'b0, '0);
    end
    // Full with a simultaneous pop: push refused, no overflow.
    x = rand_item();
    cycle(1'b1, x, rand_instr(), 1'b1, a[0]);
    n_checks++; if (ovf_flag !== 1'b0 || mdl_ready !== 1'b1 || cmp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_full_pop got ovf=%b ready=%b cv=%b exp 0/1/1", ovf_flag, mdl_ready, cmp_valid); end
    // Not full, push+pop together: occupancy stays at DEPTH-1.
    cycle(1'b1, x, rand_instr(), 1'b1, a[1]);
    n_checks++; if (mdl_ready !== 1'b1 || q.size() != DEPTH - 1 || cmp_rec !== m_rec) begin n_fail++; $display("FAIL b2b_pushpop got ready=%b rec=%h exp 1/%h", mdl_ready, cmp_rec, m_rec); end
    for (int i = 2; i < DEPTH; i++) begin
      cycle(1'b0, '0, '0, 1'b1, a[i]);
      n_checks++; if (cmp_valid !== 1'b1 || cmp_rec !== m_rec) begin n_fail++; $display("FAIL b2b_%0d got cv=%b rec=%h exp 1/%h", i, cmp_valid, cmp_rec, m_rec); end
    end
    cycle(1'b0, '0, '0, 1'b1, x);
    n_checks++; if (cmp_valid !== 1'b1 || cmp_rec.error_champ !== 3'b000 || empty !== 1'b1) begin n_fail++; $display("FAIL b2b_last got cv=%b ch=%b empty=%b exp 1/000/1", cmp_valid, cmp_rec.error_champ, empty); end
  endtask

  task automatic test_random();
    logic        mv, dv;
    data_item_t  mi, di;
    instr_item_t ins;
    int          pm, pd;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      pm = (n < 200) ? 70 : (n < 400) ? 35 : 50;
      pd = (n < 200) ? 35 : (n < 400) ? 70 : 50;
      mv  = ($urandom_range(0, 99) < pm);
      dv  = ($urandom_range(0, 99) < pd);
      mi  = rand_item();
      ins = rand_instr();
      di  = (q.size() > 0) ? q[0].item : mi;
      if ($urandom_range(0, 99) < 35) begin
        logic [2:0] flip;
        flip = 3'($urandom_range(1, 7));
        if (flip[0]) di.data  = di.data ^ (32'h1 << $urandom_range(0, 31));
        if (flip[1]) di.addr  = di.addr ^ 32'h4;
        if (flip[2]) di.write = ~di.write;
      end
      cycle(mv, mi, ins, dv, di);
      n_checks++;
      if (cmp_valid !== m_cv || cmp_error !== m_ce || cmp_rec !== m_rec)
        begin n_fail++; $display("FAIL rand_cmp_%0d got cv=%b ce=%b rec=%h exp %b/%b/%h", n, cmp_valid, cmp_error, cmp_rec, m_cv, m_ce, m_rec); end
      n_checks++;
      if (match_cnt !== 4'(m_match) || error_cnt !== 4'(m_err) || orphan_flag !== m_orph || ovf_flag !== m_ovf)
        begin n_fail++; $display("FAIL rand_stat_%0d got m=%0d e=%0d o=%b v=%b exp %0d/%0d/%b/%b", n, match_cnt, error_cnt, orphan_flag, ovf_flag, m_match, m_err, m_orph, m_ovf); end
      n_checks++;
      if (empty !== (q.size() == 0) || mdl_ready !== (q.size() < DEPTH))
        begin n_fail++; $display("FAIL rand_queue_%0d got empty=%b ready=%b exp size=%0d", n, empty, mdl_ready, q.size()); end
    end
  endtask

  initial begin
    rst = 1'b1;
    mdl_valid = 1'b0; dut_valid = 1'b0;
    mdl_item = '0; dut_item = '0; mdl_instr = '0;
    model_reset();
    test_reset();
    test_match();
    test_mismatch();
    test_full_wrap();
    test_orphan_bypass();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
